// File: rtl/cl_bram_arb_pkg.sv
// Shared types for the CL BRAM arbiter: FSM states and the response tag
// that travels alongside each accepted beat.
package cl_bram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCK0,
    ARB_LOCK1
  } arb_state_e;

  // id selects the requester channel the response is steered to
  typedef struct packed {
    logic valid;
    logic id;
    logic we;
    logic err;
  } rsp_tag_t;

endpackage

// File: rtl/cl_bram_arbiter_if.sv
// One requester's view of the shared BRAM port: valid/ready request channel
// plus a fixed-latency, non-back-pressurable response channel.
interface cl_bram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              valid;
  logic              ready;
  logic              we;
  logic              last;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output valid, we, last, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, we, last, addr, wdata,
    output ready, rvalid, rdata, err
  );

endinterface

// File: rtl/cl_bram_rsp_pipe.sv
// RD_LAT-deep shift register of response tags, aligned with the BRAM read
// latency so each tag emerges in the cycle its read data is valid.
module cl_bram_rsp_pipe
  import cl_bram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t stage_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/cl_bram_arbiter.sv
// Round-robin arbiter with burst locking in front of one BRAM port; rejects
// out-of-range addresses and returns fixed-latency responses per requester.
module cl_bram_arbiter
  import cl_bram_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  cl_bram_arbiter_if.slave  r0,
  cl_bram_arbiter_if.slave  r1,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_vld;
  logic              gnt_id;
  logic              sel_we;
  logic              sel_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  rsp_tag_t          tag_in;
  rsp_tag_t          tag_out;
  logic              rsp_valid;
  logic              rsp0;
  logic              rsp1;
  logic [DATA_W-1:0] rsp_data;

  // ptr_q names the requester that wins the next tie in ARB_IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_vld    = 1'b0;
    gnt_id     = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;

    case (state_q)
      ARB_IDLE: begin
        if (r0.valid && r1.valid) begin
          gnt_vld = 1'b1;
          gnt_id  = ptr_q;
        end else if (r0.valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (r1.valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
      // A locked requester keeps the port through idle cycles in its burst
      ARB_LOCK0: begin
        gnt_vld = r0.valid;
        gnt_id  = 1'b0;
      end
      ARB_LOCK1: begin
        gnt_vld = r1.valid;
        gnt_id  = 1'b1;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
      end
    endcase

    if (rst) begin
      gnt_vld = 1'b0;
    end

    sel_we    = gnt_id ? r1.we    : r0.we;
    sel_last  = gnt_id ? r1.last  : r0.last;
    sel_addr  = gnt_id ? r1.addr  : r0.addr;
    sel_wdata = gnt_id ? r1.wdata : r0.wdata;
    in_range  = sel_addr < ADDR_W'(DEPTH);

    if (gnt_vld) begin
      ptr_d   = ~gnt_id;
      state_d = sel_last ? ARB_IDLE : (gnt_id ? ARB_LOCK1 : ARB_LOCK0);
      if (in_range) begin
        bram_en    = 1'b1;
        bram_we    = sel_we;
        bram_addr  = sel_addr;
        bram_wdata = sel_wdata;
      end
    end

    tag_in = '{valid: gnt_vld, id: gnt_id, we: sel_we, err: ~in_range};
  end

  assign r0.ready = gnt_vld & ~gnt_id;
  assign r1.ready = gnt_vld &  gnt_id;

  cl_bram_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Responses still in flight when reset is asserted are dropped
  assign rsp_valid = tag_out.valid & ~rst;
  assign rsp_data  = (tag_out.we | tag_out.err) ? '0 : bram_rdata;
  assign rsp0      = rsp_valid & ~tag_out.id;
  assign rsp1      = rsp_valid &  tag_out.id;

  assign r0.rvalid = rsp0;
  assign r0.err    = rsp0 & tag_out.err;
  assign r0.rdata  = rsp0 ? rsp_data : '0;
  assign r1.rvalid = rsp1;
  assign r1.err    = rsp1 & tag_out.err;
  assign r1.rdata  = rsp1 ? rsp_data : '0;

endmodule

// File: tb/tb_cl_bram_arbiter.sv
// Directed bench for cl_bram_arbiter: one instance at RD_LAT=1 and one at
// RD_LAT=2, each in front of a small behavioural BRAM.
module tb_cl_bram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cl_bram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a0 ();
  cl_bram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
  cl_bram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  cl_bram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  logic        bram_en, bram_we;
  logic [31:0] bram_addr, bram_wdata, bram_rdata;
  logic        bram2_en, bram2_we;
  logic [31:0] bram2_addr, bram2_wdata, bram2_rdata;

  cl_bram_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .r0         (a0),
    .r1         (a1),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  cl_bram_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .RD_LAT(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .r0         (b0),
    .r1         (b1),
    .bram_en    (bram2_en),
    .bram_we    (bram2_we),
    .bram_addr  (bram2_addr),
    .bram_wdata (bram2_wdata),
    .bram_rdata (bram2_rdata)
  );

  // Behavioural BRAMs with 1- and 2-cycle read latency
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] rd2_s1;
  wire         unused_hi = ^{bram_addr[31:8], bram2_addr[31:8]};

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem1[bram_addr[7:0]] <= bram_wdata;
      else         bram_rdata <= mem1[bram_addr[7:0]];
    end
    if (bram2_en) begin
      if (bram2_we) mem2[bram2_addr[7:0]] <= bram2_wdata;
      else          rd2_s1 <= mem2[bram2_addr[7:0]];
    end
    bram2_rdata <= rd2_s1;
  end

  task automatic applyStimulus(input int req, input logic v, input logic we,
                               input logic last, input logic [31:0] addr,
                               input logic [31:0] wdata);
    if (req == 0) begin
      a0.valid = v; a0.we = we; a0.last = last; a0.addr = addr; a0.wdata = wdata;
    end else if (req == 1) begin
      a1.valid = v; a1.we = we; a1.last = last; a1.addr = addr; a1.wdata = wdata;
    end else begin
      b0.valid = v; b0.we = we; b0.last = last; b0.addr = addr; b0.wdata = wdata;
    end
  endtask

  task automatic idleAll();
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    applyStimulus(2, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed,
                          input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] exp_d;

    b1.valid = 1'b0; b1.we = 1'b0; b1.last = 1'b1; b1.addr = '0; b1.wdata = '0;
    rst = 1'b1;
    idleAll();
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd0);

    // Reset: outputs quiet even with a valid request present
    @(negedge clk); #1;
    checkBit("rst_ready0", a0.ready, 1'b0);
    checkBit("rst_bram_en", bram_en, 1'b0);
    checkBit("rst_rvalid0", a0.rvalid, 1'b0);
    checkOutput("rst_rdata0", a0.rdata, 32'd0);
    checkOutput("rst_bram_addr", bram_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idleAll();

    // Round-robin: both valid, single-beat writes, r0 wins first
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'd10, 32'h0000_000A);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'd11, 32'h0000_000B);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      checkBit("rr_ready0", a0.ready, (k % 2) == 0);
      checkBit("rr_ready1", a1.ready, (k % 2) == 1);
      checkOutput("rr_bram_addr", bram_addr, ((k % 2) == 0) ? 32'd10 : 32'd11);
      checkBit("rr_rvalid0", a0.rvalid, (k % 2) == 1);
      checkBit("rr_rvalid1", a1.rvalid, (k > 0) && ((k % 2) == 0));
    end
    @(negedge clk);
    idleAll();
    #1;
    checkBit("rr_tail_rvalid1", a1.rvalid, 1'b1);
    checkBit("rr_tail_rvalid0", a0.rvalid, 1'b0);

    // Single write then read of address 5
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    #1;
    checkBit("wr_ready0", a0.ready, 1'b1);
    checkBit("wr_bram_en", bram_en, 1'b1);
    checkBit("wr_bram_we", bram_we, 1'b1);
    checkOutput("wr_bram_addr", bram_addr, 32'd5);
    checkOutput("wr_bram_wdata", bram_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    #1;
    checkBit("rd_bram_we", bram_we, 1'b0);
    checkBit("wr_rsp_rvalid", a0.rvalid, 1'b1);
    checkOutput("wr_rsp_rdata", a0.rdata, 32'd0);
    checkBit("wr_rsp_err", a0.err, 1'b0);
    @(negedge clk);
    idleAll();
    #1;
    checkBit("rd_rsp_rvalid", a0.rvalid, 1'b1);
    checkOutput("rd_rsp_rdata", a0.rdata, 32'hDEAD_BEEF);
    checkBit("rd_rsp_rvalid1", a1.rvalid, 1'b0);

    // Burst lock: r1 (tie winner now) locks for 4 beats with a 2-cycle gap
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'd20, 32'h0000_0011);
    #1;
    checkBit("bl_b1_ready1", a1.ready, 1'b1);
    checkBit("bl_b1_ready0", a0.ready, 1'b0);
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'd21, 32'h0000_0022);
    #1;
    checkBit("bl_b2_ready0", a0.ready, 1'b0);
    checkBit("bl_b2_ready1", a1.ready, 1'b1);
    checkBit("bl_b2_rvalid1", a1.rvalid, 1'b1);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkBit("bl_gap1_ready0", a0.ready, 1'b0);
    checkBit("bl_gap1_bram_en", bram_en, 1'b0);
    @(negedge clk); #1;
    checkBit("bl_gap2_ready0", a0.ready, 1'b0);
    checkBit("bl_gap2_rvalid1", a1.rvalid, 1'b0);
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'd22, 32'h0000_0033);
    #1;
    checkBit("bl_b3_ready0", a0.ready, 1'b0);
    checkBit("bl_b3_ready1", a1.ready, 1'b1);
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'd23, 32'h0000_0044);
    #1;
    checkBit("bl_b4_ready0", a0.ready, 1'b0);
    checkBit("bl_b4_ready1", a1.ready, 1'b1);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    #1;
    checkBit("bl_handover_ready0", a0.ready, 1'b1);
    checkOutput("bl_handover_addr", bram_addr, 32'd5);
    checkBit("bl_b4_rvalid1", a1.rvalid, 1'b1);
    @(negedge clk);
    idleAll();
    #1;
    checkOutput("bl_r0_rdata", a0.rdata, 32'hDEAD_BEEF);

    // Range check: out-of-range read and write never reach the BRAM
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'd0, 32'h5A5A_5A5A);
    #1;
    checkBit("rc_wr0_bram_en", bram_en, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'd256, 32'd0);
    #1;
    checkBit("rc_rd256_ready", a0.ready, 1'b1);
    checkBit("rc_rd256_bram_en", bram_en, 1'b0);
    checkBit("rc_wr0_err", a0.err, 1'b0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF);
    #1;
    checkBit("rc_wr1000_bram_en", bram_en, 1'b0);
    checkBit("rc_wr1000_bram_we", bram_we, 1'b0);
    checkBit("rc_rd256_rvalid", a0.rvalid, 1'b1);
    checkBit("rc_rd256_err", a0.err, 1'b1);
    checkOutput("rc_rd256_rdata", a0.rdata, 32'd0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
    #1;
    checkBit("rc_rd0_bram_en", bram_en, 1'b1);
    checkBit("rc_wr1000_err", a0.err, 1'b1);
    checkOutput("rc_wr1000_rdata", a0.rdata, 32'd0);
    @(negedge clk);
    idleAll();
    #1;
    checkBit("rc_rd0_err", a0.err, 1'b0);
    checkOutput("rc_rd0_rdata", a0.rdata, 32'h5A5A_5A5A);

    // Reset mid-burst: r0 locks with a read in flight, then reset
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkBit("rm_lock_ready0", a0.ready, 1'b1);
    @(negedge clk);
    idleAll();
    rst = 1'b1;
    #1;
    checkBit("rm_drop_rvalid0", a0.rvalid, 1'b0);
    checkOutput("rm_drop_rdata0", a0.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'd20, 32'd0);
    #1;
    checkBit("rm_after_ready1", a1.ready, 1'b1);
    checkBit("rm_after_rvalid0", a0.rvalid, 1'b0);
    @(negedge clk);
    idleAll();
    #1;
    checkBit("rm_r1_rvalid", a1.rvalid, 1'b1);
    checkOutput("rm_r1_rdata", a1.rdata, 32'h0000_0011);

    // RD_LAT=2: writes to 0..2, then back-to-back reads, then drain
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k < 3)      applyStimulus(2, 1'b1, 1'b1, 1'b1, 32'(k), 32'hA000_0000 + 32'(k));
      else if (k < 6) applyStimulus(2, 1'b1, 1'b0, 1'b1, 32'(k - 3), 32'd0);
      else            applyStimulus(2, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      #1;
      exp_d = (k >= 5 && k <= 7) ? 32'hA000_0000 + 32'(k - 5) : 32'd0;
      checkBit("lat2_rvalid", b0.rvalid, (k >= 2) && (k <= 7));
      checkOutput("lat2_rdata", b0.rdata, exp_d);
      checkBit("lat2_err", b0.err, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cl_bram_arbiter.md
# cl_bram_arbiter

Two-requester arbiter sharing one port of the dual-port 32-bit BRAM in the CL design. Typical requesters are the host AXI-lite register bridge and the systolic-array operand loader. Each requester gets a valid/ready request channel and a fixed-latency response channel. Arbitration is round-robin with optional burst locking, and out-of-range addresses are rejected without touching the BRAM.

## Interface
Parameters:
- DATA_W, 32, data width of the BRAM port
- ADDR_W, 32, address width of the BRAM port
- DEPTH, 256, number of valid BRAM words; addresses >= DEPTH are illegal
- RD_LAT, 1, BRAM read latency in cycles (>= 1)

Ports. The `{r0,r1}_` prefix means one identical port per requester.
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- {r0,r1}_valid  in  1  request beat valid
- {r0,r1}_ready  out  1  request beat accepted this cycle
- {r0,r1}_we  in  1  1 = write, 0 = read
- {r0,r1}_last  in  1  final beat of burst; 0 locks the grant to this requester
- {r0,r1}_addr  in  ADDR_W  word address
- {r0,r1}_wdata  in  DATA_W  write data
- {r0,r1}_rvalid  out  1  one-cycle response pulse
- {r0,r1}_rdata  out  DATA_W  read data (0 for writes and errors)
- {r0,r1}_err  out  1  address-range error, qualified by rvalid
- bram_en  out  1  BRAM port enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM read data

## Operation
- **States:** ARB_IDLE, ARB_LOCK0, ARB_LOCK1.
- **ARB_IDLE grant:**
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - Priority pointer updates on every accepted beat.
- **Entering a lock:** an accepted beat with last=0 moves the arbiter to ARB_LOCKn for the granted requester n.
- **In ARB_LOCKn:**
  - Only rn can be granted. The other requester is held off even while rn_valid=0, so idle cycles inside a burst are legal.
  - An accepted rn beat with last=1 returns the arbiter to ARB_IDLE.
- **Accept rule:** a beat is accepted when rn_valid & rn_ready. At most one beat is accepted per cycle.
- **In-range beat (addr < DEPTH):** in the accept cycle, bram_en=1, bram_we=rn_we, and bram_addr/bram_wdata are driven from rn_addr/rn_wdata.
- **Out-of-range beat:** bram_en=0 and the BRAM is untouched. The beat is still accepted, and its response has err=1.
- **Responses:** every accepted beat produces exactly one response on its own requester's channel.
  - Read: rdata = bram_rdata.
  - Write or error: rdata = 0.
  - Responses cannot be back-pressured.
- **Response tags:** {valid, id, we, err} is carried through an RD_LAT-deep tag pipeline, which steers the response to the correct requester.
- **Reset values:**
  - All ready, rvalid, err and bram_en/bram_we outputs are 0.
  - rdata, bram_addr and bram_wdata are 0.
  - State is ARB_IDLE; the pointer is set so r0 wins the first tie; the tag pipeline is cleared.
- **Reset mid-operation:** the burst lock is released and in-flight responses are dropped, i.e. no rvalid is issued for them.

## Timing
- rn_ready and all bram_* request outputs are combinational from valid, last, addr, state and pointer. There is no ready-before-valid requirement.
- Accept at cycle t produces rn_rvalid in cycle t+RD_LAT. With RD_LAT=1, rdata is sampled from bram_rdata in that cycle.
- Full throughput: one beat per cycle, back-to-back, including alternating requesters.
- Burst handover has no bubble. If r0 is accepted with last=1 at cycle t, r1 can be accepted at t+1.
- Reads and writes to the same address are handled as in-order BRAM accesses. A read accepted after a write returns the new data.

## Structure
- Package cl_bram_arb_pkg holds:
  - enum arb_state_e {ARB_IDLE, ARB_LOCK0, ARB_LOCK1}
  - struct rsp_tag_t {valid, id, we, err}
  - localparam NUM_REQ = 2
- Sub-module cl_bram_rsp_pipe implements the RD_LAT-deep shift register of rsp_tag_t, with synchronous clear on rst.
- cl_bram_arbiter contains the FSM, the round-robin pointer, the range check, request muxing and response demux.

## Test plan
- **Single reads:** r0 writes 0xDEADBEEF to address 5, then reads address 5 → one write response (rdata=0, err=0), then a read response 1 cycle after accept with rdata=0xDEADBEEF.
- **Round-robin:** both requesters valid continuously with last=1 → grants alternate r0, r1, r0, r1 starting with r0, one beat per cycle, each rvalid on the correct channel.
- **Burst lock:** r1 sends 4 beats (last on the 4th) while r0 is held valid → r0_ready=0 for all 4 cycles, including a 2-cycle r1_valid gap mid-burst; r0 is granted the cycle after r1's last beat.
- **Range check:** r0 reads address 256 and writes address 0x1000 → bram_en=0 in both accept cycles, both responses have err=1 and rdata=0, and BRAM contents are unchanged.
- **Reset mid-burst:** rst asserted while in ARB_LOCK0 with one read in flight → no rvalid for that read, state returns to ARB_IDLE, and after reset r1 is granted immediately if it is the only requester valid.
- **Latency parameter:** with RD_LAT=2, back-to-back reads at addresses 0, 1, 2 → rvalid at t+2, t+3, t+4 with data in order.
